// File: rtl/md_scheduler.sv
// md_scheduler: multiply/divide scheduler beside the E stage.
// Computes the result at start, holds it pending for a fixed latency,
// then commits it to HI/LO. Owns HI/LO and the D-stage MDU interlock.
module md_scheduler #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        RESET,
  input  logic        E_MDStart,
  input  logic [1:0]  E_MDOp,
  input  logic        E_HIWrite,
  input  logic        E_LOWrite,
  input  logic [31:0] E_A,
  input  logic [31:0] E_B,
  input  logic        D_MDUse,
  output logic        MD_Busy,
  output logic        STALL,
  output logic        STALL_RESET,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CW = $clog2(MAX_CYCLES + 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [31:0]   hi_q, hi_nxt, lo_q, lo_nxt;
  logic [31:0]   pend_hi, pend_hi_nxt, pend_lo, pend_lo_nxt;
  logic          pend_wr, pend_wr_nxt;

  logic          is_signed, is_div, div_zero;
  logic [31:0]   abs_a, abs_b, dvd, dvs, quo, rem;
  logic [63:0]   mul_a, mul_b, prod;
  logic [31:0]   res_hi, res_lo;
  logic          res_wr;

  // Result datapath: one multiplier and one magnitude divider, sign fixed up after.
  // Signed overflow (0x80000000 / -1) falls out naturally: |q| = 0x80000000, negated = itself.
  always_comb begin
    is_signed = ~E_MDOp[0];
    is_div    = E_MDOp[1];
    div_zero  = (E_B == '0);
    abs_a     = E_A[31] ? (~E_A + 32'd1) : E_A;
    abs_b     = E_B[31] ? (~E_B + 32'd1) : E_B;
    mul_a     = is_signed ? {{32{E_A[31]}}, E_A} : {32'd0, E_A};
    mul_b     = is_signed ? {{32{E_B[31]}}, E_B} : {32'd0, E_B};
    prod      = mul_a * mul_b;
    dvd       = is_signed ? abs_a : E_A;
    dvs       = div_zero ? 32'd1 : (is_signed ? abs_b : E_B);
    quo       = dvd / dvs;
    rem       = dvd % dvs;
    res_wr    = 1'b1;
    if (is_div) begin
      res_lo = (is_signed && (E_A[31] ^ E_B[31])) ? (~quo + 32'd1) : quo;
      res_hi = (is_signed && E_A[31]) ? (~rem + 32'd1) : rem;
      res_wr = ~div_zero;
    end else begin
      res_hi = prod[63:32];
      res_lo = prod[31:0];
    end
  end

  // Next-state: start/mthi/mtlo accepted only in IDLE; commit on last busy cycle.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    hi_nxt      = hi_q;
    lo_nxt      = lo_q;
    pend_hi_nxt = pend_hi;
    pend_lo_nxt = pend_lo;
    pend_wr_nxt = pend_wr;
    case (state)
      IDLE: begin
        if (E_MDStart) begin
          pend_hi_nxt = res_hi;
          pend_lo_nxt = res_lo;
          pend_wr_nxt = res_wr;
          cnt_nxt     = is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
          state_nxt   = BUSY;
        end else begin
          if (E_HIWrite) hi_nxt = E_A;
          if (E_LOWrite) lo_nxt = E_A;
        end
      end
      BUSY: begin
        if (cnt == CW'(1)) begin
          if (pend_wr) begin
            hi_nxt = pend_hi;
            lo_nxt = pend_lo;
          end
          cnt_nxt   = '0;
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, counter, pending result and HI/LO registers.
  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      state   <= IDLE;
      cnt     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      pend_hi <= '0;
      pend_lo <= '0;
      pend_wr <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      hi_q    <= hi_nxt;
      lo_q    <= lo_nxt;
      pend_hi <= pend_hi_nxt;
      pend_lo <= pend_lo_nxt;
      pend_wr <= pend_wr_nxt;
    end
  end

  // Outputs: busy decoded from the state register, interlock is combinational.
  always_comb begin
    MD_Busy     = (state == BUSY);
    STALL       = D_MDUse & (E_MDStart | MD_Busy);
    STALL_RESET = STALL;
    HI          = hi_q;
    LO          = lo_q;
  end

endmodule

// File: tb/tb_md_scheduler.sv
// tb_md_scheduler: scoreboard bench for md_scheduler.
module tb_md_scheduler;

  logic        clk = 1'b0;
  logic        RESET;
  logic        E_MDStart, E_HIWrite, E_LOWrite, D_MDUse;
  logic [1:0]  E_MDOp;
  logic [31:0] E_A, E_B;
  logic        MD_Busy, STALL, STALL_RESET;
  logic [31:0] HI, LO;

  int errors = 0;
  int checks = 0;
  logic [63:0] sb_q[$];
  logic [31:0] m_hi, m_lo;

  md_scheduler #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .RESET(RESET), .E_MDStart(E_MDStart), .E_MDOp(E_MDOp),
    .E_HIWrite(E_HIWrite), .E_LOWrite(E_LOWrite), .E_A(E_A), .E_B(E_B),
    .D_MDUse(D_MDUse), .MD_Busy(MD_Busy), .STALL(STALL),
    .STALL_RESET(STALL_RESET), .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model of one MDU operation; returns {HI,LO}.
  function automatic logic [63:0] ref_result(input logic [1:0] op, input logic [31:0] a, b, hi, lo);
    longint          sa, sb;
    longint unsigned ua, ub;
    int              ia, ib;
    case (op)
      2'd0: begin sa = longint'($signed(a)); sb = longint'($signed(b)); return 64'(sa * sb); end
      2'd1: begin ua = {32'd0, a}; ub = {32'd0, b}; return ua * ub; end
      2'd2: begin
        if (b == 32'd0) return {hi, lo};
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'd0, 32'h80000000};
        ia = a; ib = b;
        return {32'(ia % ib), 32'(ia / ib)};
      end
      default: begin
        if (b == 32'd0) return {hi, lo};
        return {a % b, a / b};
      end
    endcase
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // mthi/mtlo in IDLE; expected state pushed before drive.
  task automatic mt_write(input string tag, input logic hw, input logic lw, input logic [31:0] val);
    logic [63:0] exp;
    sb_q.push_back({hw ? val : m_hi, lw ? val : m_lo});
    E_HIWrite = hw; E_LOWrite = lw; E_A = val;
    next_cycle();
    E_HIWrite = 1'b0; E_LOWrite = 1'b0; E_A = $urandom;
    check_val({tag, " busy"}, 64'(MD_Busy), 64'd0);
    exp = sb_q.pop_front();
    check_val({tag, " hilo"}, {HI, LO}, exp);
    {m_hi, m_lo} = exp;
  endtask

  // Run one op; expected {HI,LO} must already be on the scoreboard.
  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a, b,
                        input logic duse, input logic wr, input logic viol);
    int n = op[1] ? 10 : 5;
    int busy = 0;
    logic [63:0] exp;
    E_MDStart = 1'b1; E_MDOp = op; E_A = a; E_B = b; D_MDUse = duse;
    E_HIWrite = wr; E_LOWrite = wr;
    #1;
    check_val({tag, " stall@start"}, 64'(STALL), 64'(duse));
    check_val({tag, " stall_reset@start"}, 64'(STALL_RESET), 64'(duse));
    next_cycle();
    E_MDStart = 1'b0; E_HIWrite = 1'b0; E_LOWrite = 1'b0;
    E_A = $urandom; E_B = $urandom;
    while (MD_Busy && busy < 40) begin
      busy++;
      check_val({tag, " hilo held"}, {HI, LO}, {m_hi, m_lo});
      check_val({tag, " stall busy"}, 64'(STALL), 64'(duse));
      if (viol && busy == 2) begin
        E_MDStart = 1'b1; E_MDOp = 2'd1; E_HIWrite = 1'b1; E_LOWrite = 1'b1;
      end else begin
        E_MDStart = 1'b0; E_HIWrite = 1'b0; E_LOWrite = 1'b0;
      end
      next_cycle();
    end
    E_MDStart = 1'b0; E_HIWrite = 1'b0; E_LOWrite = 1'b0;
    check_val({tag, " busy cycles"}, 64'(busy), 64'(n));
    check_val({tag, " stall after"}, 64'(STALL), 64'd0);
    exp = sb_q.pop_front();
    check_val({tag, " result"}, {HI, LO}, exp);
    {m_hi, m_lo} = exp;
    D_MDUse = 1'b0;
  endtask

  initial begin
    logic [1:0]  op;
    logic [31:0] a, b;
    RESET = 1'b1; E_MDStart = 1'b0; E_MDOp = '0; E_HIWrite = 1'b0; E_LOWrite = 1'b0;
    E_A = '0; E_B = '0; D_MDUse = 1'b0;
    m_hi = '0; m_lo = '0;
    repeat (2) @(posedge clk);
    #3 RESET = 1'b0;
    next_cycle();
    check_val("reset busy", 64'(MD_Busy), 64'd0);
    check_val("reset hilo", {HI, LO}, 64'd0);

    // mult 7 * -3
    sb_q.push_back({32'hFFFFFFFF, 32'hFFFFFFEB});
    run_op("mult", 2'd0, 32'd7, 32'hFFFFFFFD, 1'b0, 1'b0, 1'b0);
    // divu / div sign
    sb_q.push_back({32'd2, 32'd14});
    run_op("divu", 2'd3, 32'd100, 32'd7, 1'b0, 1'b0, 1'b0);
    sb_q.push_back({32'hFFFFFFFF, 32'hFFFFFFFD});
    run_op("div neg", 2'd2, 32'hFFFFFFF9, 32'd2, 1'b0, 1'b0, 1'b0);
    // divide by zero keeps HI/LO, overflow case
    mt_write("mthi11", 1'b1, 1'b0, 32'h11);
    mt_write("mtlo22", 1'b0, 1'b1, 32'h22);
    sb_q.push_back({32'h11, 32'h22});
    run_op("div0", 2'd2, 32'd55, 32'd0, 1'b0, 1'b0, 1'b0);
    sb_q.push_back({32'h11, 32'h22});
    run_op("divu0", 2'd3, 32'd9, 32'd0, 1'b0, 1'b0, 1'b0);
    sb_q.push_back({32'd0, 32'h80000000});
    run_op("div ovf", 2'd2, 32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0);
    // interlock with mflo behind
    sb_q.push_back({32'h0, 32'd391});
    run_op("stall mult", 2'd1, 32'd17, 32'd23, 1'b1, 1'b0, 1'b0);
    // mthi alone, then mthi/mtlo colliding with multu start
    mt_write("mthi", 1'b1, 1'b0, 32'hDEADBEEF);
    sb_q.push_back({32'd0, 32'd12});
    run_op("start wins", 2'd1, 32'd3, 32'd4, 1'b0, 1'b1, 1'b0);
    // requests while busy are ignored
    sb_q.push_back({32'hFFFFFFFF, 32'hFFFFFF88});
    run_op("busy viol", 2'd0, 32'hFFFFFFF6, 32'd12, 1'b0, 1'b0, 1'b1);
    // random ops against the model
    for (int i = 0; i < 8; i++) begin
      op = 2'($urandom_range(0, 3));
      a = $urandom;
      b = (i == 5) ? 32'd0 : $urandom >> $urandom_range(0, 28);
      sb_q.push_back(ref_result(op, a, b, m_hi, m_lo));
      run_op("rand", op, a, b, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
    end

    // async reset mid-div discards the pending result
    mt_write("mtlo pre", 1'b0, 1'b1, 32'h5A5A5A5A);
    E_MDStart = 1'b1; E_MDOp = 2'd3; E_A = 32'd1000; E_B = 32'd3;
    next_cycle();
    E_MDStart = 1'b0;
    repeat (3) next_cycle();
    check_val("pre-reset busy", 64'(MD_Busy), 64'd1);
    #2 RESET = 1'b1;
    #1;
    check_val("async busy", 64'(MD_Busy), 64'd0);
    check_val("async hilo", {HI, LO}, 64'd0);
    @(posedge clk);
    #3 RESET = 1'b0;
    m_hi = '0; m_lo = '0;
    for (int i = 0; i < 12; i++) begin
      next_cycle();
      if (i == 0 || i == 11) begin
        check_val("post-reset busy", 64'(MD_Busy), 64'd0);
        check_val("post-reset hilo", {HI, LO}, 64'd0);
      end
    end
    sb_q.push_back({32'd0, 32'd42});
    run_op("mult after reset", 2'd0, 32'd6, 32'd7, 1'b0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/md_scheduler.md
Name: md_scheduler

Overview:
- Multiply/divide scheduler for the 5-stage MIPS pipeline. Sits beside the E stage.
- Accepts mult/multu/div/divu/mthi/mtlo from E and models fixed multi-cycle latency.
- Owns the HI/LO registers.
- Generates the stall that freezes F/D and the STALL_RESET bubble into the D/E pipeline register while a D-stage MDU instruction must wait.

Parameters:
MULT_CYCLES, 5, busy cycles for mult/multu (>=1)
DIV_CYCLES, 10, busy cycles for div/divu (>=1)

Ports:
clk  input  1  clock, all state on rising edge
RESET  input  1  asynchronous active-high reset
E_MDStart  input  1  E-stage holds valid mult/multu/div/divu this cycle
E_MDOp  input  2  0=mult, 1=multu, 2=div, 3=divu
E_HIWrite  input  1  E-stage mthi
E_LOWrite  input  1  E-stage mtlo
E_A  input  32  forwarded rs value
E_B  input  32  forwarded rt value
D_MDUse  input  1  D-stage instr is mult/multu/div/divu/mfhi/mflo/mthi/mtlo
MD_Busy  output  1  operation in flight
STALL  output  1  freeze PC and F/D register
STALL_RESET  output  1  insert bubble into D/E register
HI  output  32  HI register
LO  output  32  LO register

Behaviour:
- Reset: asynchronous. Forces state IDLE, counter 0, HI=0, LO=0, pending result 0, MD_Busy=0. Releases on the first clk edge after RESET deasserts. Reset mid-operation discards the pending result; HI/LO read 0.
- States:
  - IDLE: on edge with E_MDStart=1, latch computed result into internal pending regs, load counter with MULT_CYCLES (op 0/1) or DIV_CYCLES (op 2/3), go BUSY.
  - BUSY: counter decrements each edge. On the edge where counter==1, commit pending HI/LO, counter->0, go IDLE.
- MD_Busy = (state==BUSY), registered.
- Timing: start sampled at end of cycle t; MD_Busy high cycles t+1..t+N; new HI/LO visible from cycle t+N+1.
- STALL = D_MDUse & (E_MDStart | MD_Busy), combinational. STALL_RESET = STALL.
- Arithmetic:
  - mult: {HI,LO} = signed 64-bit product.
  - multu: {HI,LO} = unsigned 64-bit product.
  - div: LO = signed quotient truncated toward zero, HI = remainder with the sign of the dividend (E_A).
  - divu: LO = unsigned quotient, HI = unsigned remainder.
  - Signed overflow 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
  - Divisor 0 (div or divu): op still runs full DIV_CYCLES and MD_Busy behaves normally; HI and LO are unchanged at commit.
- mthi/mtlo: in IDLE, HI<=E_A (E_HIWrite) or LO<=E_A (E_LOWrite) at the next edge. Both may be asserted together.
- Simultaneous E_MDStart and E_HIWrite/E_LOWrite: E_MDStart wins; the writes are ignored.
- E_MDStart, E_HIWrite or E_LOWrite while BUSY is a protocol violation (prevented by STALL). Required response: ignore the request; the current op completes unchanged.
- Operands are captured at start; E_A/E_B changes during BUSY have no effect.
- mfhi/mflo read HI/LO directly. The stall guarantees they are never read while BUSY.

Test Plan:
1. mult E_A=7, E_B=0xFFFFFFFD, one-cycle start -> MD_Busy high exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFEB. HI/LO unchanged during busy.
2. divu E_A=100, E_B=7 -> MD_Busy 10 cycles; then LO=14, HI=2. div E_A=0xFFFFFFF9 (-7), E_B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
3. HI=0x11, LO=0x22, then div by 0 -> busy 10 cycles; HI=0x11, LO=0x22 after. div 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
4. Start mult with D_MDUse=1 (mflo behind) -> STALL and STALL_RESET high in start cycle plus 5 busy cycles (6 total), low in cycle t+6; LO valid in that cycle. D_MDUse=0 during busy -> STALL=0.
5. mthi E_A=0xDEADBEEF while IDLE -> HI=0xDEADBEEF next cycle, LO unchanged, MD_Busy stays 0. Same cycle as E_MDStart(multu 3*4) -> mthi ignored, HI=0, LO=12 after 5 cycles.
6. Assert RESET asynchronously (between edges) at busy cycle 4 of a div -> MD_Busy, HI, LO go 0 immediately without a clock edge. No late commit after release. New mult after release completes normally.
